// File: rtl/spi_lcd_pkg.sv
// rtl/spi_lcd_pkg.sv - shared register map, state and FIFO entry types for spi_lcd_target
// Purpose: register offsets, register bit positions, receive FSM states and
//          the {dc, byte} FIFO entry layout used across the block.
// Ports:   none (package).
package spi_lcd_pkg;

  // Register offsets, decoded from address_in[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // DATA register
  localparam int DATA_DC_BIT    = 8;
  localparam int DATA_VALID_BIT = 31;

  // STATUS register
  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_OVF_BIT   = 18;
  localparam int ST_FERR_BIT  = 19;
  localparam int ST_CS_BIT    = 20;

  // CTRL register
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spi_lcd_target_if.sv
// rtl/spi_lcd_target_if.sv - memory-mapped peripheral bus bundle for spi_lcd_target
// Purpose: groups the single-cycle peripheral bus signals.
// Ports:   address_in/sel_in/read_in/write_mask_in/write_value_in driven by the
//          master; read_value_out/ready_out driven by the slave peripheral.
interface spi_lcd_target_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/spi_lcd_fifo.sv
// rtl/spi_lcd_fifo.sv - synchronous FIFO of {dc, byte} entries
// Purpose: DEPTH-entry FIFO; simultaneous push and pop both take effect even
//          when full, flush empties it and beats any push in the same cycle.
// Ports:   clk, reset_n; push/wr_data; pop/rd_data (head, valid when !empty);
//          flush; full, empty, count.
module spi_lcd_fifo
  import spi_lcd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  fifo_entry_t              wr_data,
  input  logic                     pop,
  output fifo_entry_t              rd_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/spi_lcd_target.sv
// rtl/spi_lcd_target.sv - SPI mode-0 LCD link target with bus-visible receive FIFO
// Purpose: oversamples spi_clk/spi_mosi/spi_cs_n/lcd_dc in the clk domain,
//          assembles MSB-first bytes tagged with dc, buffers them, and exposes
//          DATA/STATUS/CTRL registers on the peripheral bus.
// Ports:   clk, reset_n (sync, active low); spi_clk, spi_mosi, spi_cs_n,
//          lcd_dc (async SPI link inputs); bus (peripheral bus slave).
module spi_lcd_target
  import spi_lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  input  logic             spi_cs_n,
  input  logic             lcd_dc,
  spi_lcd_target_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- input synchronizers ----------------
  logic [SYNC_STAGES-1:0] sclk_pipe, mosi_pipe, cs_pipe, dc_pipe;
  logic sclk_prev, cs_prev;
  logic sclk_s, mosi_s, cs_s, dc_s;
  logic sclk_rise, cs_fall, cs_rise;

  // cs_n chain and its edge history reset low: a frame still in progress when
  // reset releases never shows a falling edge, so it is ignored until cs_n
  // goes high and falls again.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      cs_pipe   <= '0;
      dc_pipe   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi_clk};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
      dc_pipe   <= {dc_pipe[SYNC_STAGES-2:0], lcd_dc};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
  assign cs_s      = cs_pipe[SYNC_STAGES-1];
  assign dc_s      = dc_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev;

  // ---------------- bus decode ----------------
  logic        sel_rd, wr_any, st_wr, ctrl_wr, flush, fifo_pop;
  logic [1:0]  reg_addr;
  logic [31:0] wdata;

  assign reg_addr = bus.address_in[3:2];
  assign wdata    = bus.write_value_in;
  assign sel_rd   = bus.sel_in & bus.read_in;
  assign wr_any   = bus.sel_in & (|bus.write_mask_in);
  assign st_wr    = wr_any & (reg_addr == REG_STATUS) & bus.write_mask_in[2];
  assign ctrl_wr  = wr_any & (reg_addr == REG_CTRL) & bus.write_mask_in[0];
  assign flush    = ctrl_wr & wdata[CTRL_FLUSH_BIT];
  assign fifo_pop = sel_rd & (reg_addr == REG_DATA);

  // ---------------- receive FSM ----------------
  rx_state_t   state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  shift_q, shift_n;
  logic        push_q, push_n;
  fifo_entry_t push_entry, entry_n;
  logic        ferr_set;
  logic        enable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift_q    <= 7'd0;
      push_q     <= 1'b0;
      push_entry <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_q    <= shift_n;
      push_q     <= push_n;
      push_entry <= entry_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    push_n    = 1'b0;
    entry_n   = push_entry;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && cs_fall) begin
          state_n   = SHIFT;
          bit_cnt_n = 3'd0;
        end
      end
      SHIFT: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (cs_rise) begin
          state_n  = IDLE;
          ferr_set = (bit_cnt != 3'd0);
        end else if (sclk_rise) begin
          shift_n   = {shift_q[5:0], mosi_s};
          bit_cnt_n = bit_cnt + 3'd1;
          // Eighth bit: the byte is complete; the FIFO write lands next cycle.
          if (bit_cnt == 3'd7) begin
            push_n       = 1'b1;
            entry_n.dc   = dc_s;
            entry_n.data = {shift_q, mosi_s};
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  fifo_entry_t     head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  spi_lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_q),
    .wr_data (push_entry),
    .pop     (fifo_pop),
    .rd_data (head),
    .flush   (flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------- sticky flags and control ----------------
  logic overflow, frame_err, ovf_set;

  // Dropped only when full with no same-cycle pop; a flush discards silently.
  assign ovf_set = push_q & fifo_full & ~fifo_pop & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      enable    <= 1'b1;
    end else begin
      overflow  <= ovf_set  | (overflow  & ~(st_wr & wdata[ST_OVF_BIT]));
      frame_err <= ferr_set | (frame_err & ~(st_wr & wdata[ST_FERR_BIT]));
      if (ctrl_wr) enable <= wdata[CTRL_EN_BIT];
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (sel_rd) begin
      case (reg_addr)
        REG_DATA: begin
          if (!fifo_empty) begin
            rdata[7:0]            = head.data;
            rdata[DATA_DC_BIT]    = head.dc;
            rdata[DATA_VALID_BIT] = 1'b1;
          end
        end
        REG_STATUS: begin
          rdata[8:0]          = 9'(fifo_count);
          rdata[ST_EMPTY_BIT] = fifo_empty;
          rdata[ST_FULL_BIT]  = fifo_full;
          rdata[ST_OVF_BIT]   = overflow;
          rdata[ST_FERR_BIT]  = frame_err;
          rdata[ST_CS_BIT]    = ~cs_s;
        end
        REG_CTRL: rdata[CTRL_EN_BIT] = enable;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.read_value_out = rdata;
  assign bus.ready_out      = bus.sel_in;

  logic unused_bus;
  assign unused_bus = ^{bus.address_in[31:4], bus.address_in[1:0],
                        wdata[31:20], wdata[17:2],
                        bus.write_mask_in[3], bus.write_mask_in[1]};
endmodule

// File: doc/spi_lcd_target.md
Name: spi_lcd_target

Overview:
SPI target (mode 0, MSB first) that is the receiving end of the SoC's LCD SPI link (spi_clk/spi_mosi/spi_cs_n/lcd_dc).
- Oversamples the link in the clk domain and assembles bytes.
- Tags each byte with the DC level and buffers it in a FIFO.
- Exposes the FIFO and status on the standard memory-mapped peripheral bus (address_in/sel_in/read_in/write_mask_in...).
- Serves as a loopback/self-test peripheral and as a synthesizable LCD-side model for system verification.

Parameters:
FIFO_DEPTH, 16, entries of {dc, byte}; power of 2, 2..256
SYNC_STAGES, 2, synchronizer flops on each SPI input; >=2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
spi_clk  in  1  SPI serial clock from initiator, async to clk
spi_mosi  in  1  serial data, sampled on spi_clk rising edge
spi_cs_n  in  1  active-low frame select
lcd_dc  in  1  data/command tag, sampled with bit 7 (last bit) of each byte
address_in  in  32  bus address; only [3:2] decoded
sel_in  in  1  block selected this cycle
read_in  in  1  read access
read_value_out  out  32  read data; 0 when sel_in=0 (OR-combined bus)
write_mask_in  in  4  byte write strobes; nonzero = write
write_value_in  in  32  write data
ready_out  out  1  = sel_in (single-cycle access)

Behaviour:
- Reset state (reset_n=0 at posedge clk):
  - FIFO empty; counters 0; flags 0; enable=1.
  - read_value_out=0; ready_out follows sel_in.
- Input synchronization:
  - spi_clk, spi_mosi, spi_cs_n, lcd_dc each pass through SYNC_STAGES flops.
  - Rising-edge detect on synchronized sclk.
  - Supported rate: f(spi_clk) <= f(clk)/4.
- Receive FSM states: IDLE, SHIFT.
  - IDLE: on synced cs_n falling -> SHIFT; bit_cnt=0.
  - SHIFT: on each sclk rise, shift = {shift[6:0], mosi}; bit_cnt++.
  - SHIFT: when bit_cnt wraps 7->0, push {dc_sync, byte}; stay in SHIFT (back-to-back bytes within one frame).
  - SHIFT: on synced cs_n rising -> IDLE.
  - If bit_cnt != 0 at cs_n rise: partial byte discarded; frame_err sticky set.
  - enable=0: FSM held in IDLE, no pushes.
- FIFO:
  - Push occurs 1 clk after the detecting edge.
  - Push when full: byte dropped, overflow sticky set.
  - Push and pop in the same cycle are both performed, including when full; count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2+1 bits.
- Register map (address_in[3:2]):
  - 0 DATA (read):
    - [7:0] byte, [8] dc, [31] valid (=!empty).
    - Read with !empty pops in that cycle.
    - Read when empty returns 0, no pop, no underflow state.
    - Writes ignored.
  - 1 STATUS (read):
    - [8:0] count, [16] empty, [17] full, [18] overflow, [19] frame_err, [20] cs_active (synced !cs_n).
    - Write: bit18/bit19 = 1 clears the flag (W1C).
    - A set and a clear of the same flag in the same cycle: set wins.
  - 2 CTRL (R/W):
    - [0] enable.
    - [1] flush: write 1 empties FIFO in that cycle; self-clears; reads 0.
    - Flush and push in the same cycle: flush wins, byte lost, no flag.
  - 3: reads 0; writes ignored.
- Read data is combinational from current state in the sel cycle; the pop takes effect at that clock edge.
- reset_n mid-frame: the frame is abandoned and the FSM is in IDLE.
  - If cs_n is still low after reset, the FSM stays IDLE until the next cs_n falling edge.
  - The remainder of the current frame is ignored without setting frame_err.

Decomposition:
- Package spi_lcd_pkg:
  - register offset constants: REG_DATA, REG_STATUS, REG_CTRL.
  - status/ctrl bit-index localparams.
  - rx_state_t enum {IDLE, SHIFT}.
  - fifo_entry_t packed struct {dc, data[7:0]}.
- One sub-module: spi_lcd_fifo.
  - Synchronous FIFO, parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count.
- Synchronizers and FSM stay inline.

Test Plan:
1. reset_n=0 for 2 clks, then a STATUS read -> 0x00010000 (empty=1, count=0); DATA read -> 0x00000000.
2. Frame with cs_n low, bytes 0x2A (dc=0) and 0xA5 (dc=1), sclk=clk/8, then cs_n high.
   - STATUS count=2.
   - DATA reads -> 0x8000002A, then 0x800001A5, then 0x00000000.
3. 17 bytes 0x00..0x10 with no reads.
   - full=1, overflow=1, count=16; 0x10 lost.
   - Write STATUS 0x00040000 -> overflow cleared.
4. cs_n raised after 5 bits.
   - frame_err=1; count unchanged.
   - The next full byte 0x3C is received correctly -> DATA 0x8000003C.
5. FIFO full while CPU pops the DATA register on the exact cycle a new byte 0x77 completes.
   - No overflow; count stays 16; last entry 0x77.
6. Reset asserted after 4 bits of 0xF0, released with cs_n still low, 4 more sclks, then cs_n high.
   - count=0; frame_err=0.
   - CTRL write 0x1, then flush -> empty=1.
